mcu_ctrl_bridge: RTL
====================

MCU_CTRL_BRIDGE -- requirements
Module: mcu_ctrl_bridge

Interface
REQ-001 Parameter NUM_CH, default 4: number of control/status channels, legal range 1-16.
REQ-002 Parameter DATA_W, default 16: width of each channel register, legal range 8-32.
REQ-003 Parameter WDOG_CYC, default 100000000: watchdog timeout in clock cycles, used only when MCU_CTRL_WDOG_EN is defined.
REQ-004 Derived constant ADDR_W = clog2(NUM_CH)+2: low 2 bits select the register, upper bits select the channel.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 SysClk  in  1  sole clock; all logic rising-edge.
REQ-007 sRst  in  1  synchronous active-high reset.
REQ-008 sMcuCmdValid  in  1  command present from MCU.
REQ-009 sMcuCmdReady  out  1  bridge accepts a command.
REQ-010 sMcuCmdWr  in  1  1 = write, 0 = read.
REQ-011 sMcuCmdAddr  in  ADDR_W  channel/register address.
REQ-012 sMcuCmdWdata  in  DATA_W  write data.
REQ-013 sMcuRspValid  out  1  response available.
REQ-014 sMcuRspReady  in  1  MCU consumes the response.
REQ-015 sMcuRspRdata  out  DATA_W  read data; 0 for writes and errors.
REQ-016 sMcuRspErr  out  1  address out of range.
REQ-017 sChCtrl  out  NUM_CH*DATA_W  control outputs; channel n occupies bits [n*DATA_W +: DATA_W].
REQ-018 sChStatus  in  NUM_CH*DATA_W  raw status inputs, synchronous to SysClk.
REQ-019 sChIrq  out  NUM_CH  per-channel OR-reduction of (sticky AND irq-mask).
REQ-020 sWdogExpired  out  1  watchdog tripped; tied 0 when MCU_CTRL_WDOG_EN is not defined.

Function
REQ-021 Register map per channel: offset 0 CTRL (RW); offset 1 MODE (RW; a 1 makes the matching CTRL bit a pulse bit); offset 2 STATUS (RO, raw sChStatus); offset 3 STICKY (read returns sticky bits; write is write-1-to-clear).
REQ-022 Bits [DATA_W-1:DATA_W/2] of MODE also act as the irq-mask for STICKY bits [DATA_W/2-1:0]; STICKY bits [DATA_W-1:DATA_W/2] have no mask and never drive sChIrq.
REQ-023 FSM states and transitions:
- IDLE -> EXEC on sMcuCmdValid && sMcuCmdReady;
- EXEC -> RESP unconditionally;
- RESP -> IDLE on sMcuRspReady.
REQ-024 sMcuCmdReady = 1 only in IDLE; sMcuRspValid = 1 only in RESP.
REQ-025 Command and address are latched on acceptance; a write takes effect at the end of the EXEC cycle; sMcuRspValid rises 2 cycles after the accept edge.
REQ-026 Response fields hold stable while sMcuRspValid=1 and sMcuRspReady=0.
REQ-027 Channel index >= NUM_CH: no register changes, sMcuRspErr=1, sMcuRspRdata=0.
REQ-028 Pulse bits: a written 1 appears on sChCtrl for exactly one cycle, then clears to 0; reading CTRL returns 0 for pulse bits.
REQ-029 STICKY bit sets on a rising edge of the matching sChStatus bit, detected against a one-cycle-delayed copy.
REQ-030 A STICKY set and a W1C clear of the same bit in the same cycle: set wins.
REQ-031 sChIrq is registered: 1 cycle of latency from the sticky update.

Reset
REQ-032 On sRst=1, all of the following are cleared:
- FSM -> IDLE;
- CTRL, MODE and STICKY = 0;
- status delay registers = 0;
- sMcuRspValid=0, sMcuRspErr=0, sMcuRspRdata=0;
- sChIrq=0, sWdogExpired=0, watchdog counter=0.
REQ-033 sMcuCmdReady=0 while sRst=1; it is 1 on the first cycle after sRst deasserts.
REQ-034 Reset asserted mid-transaction abandons the command; no partial register update and no response.

Configuration
REQ-035 With MCU_CTRL_WDOG_EN defined:
- a counter increments every cycle and clears on each accepted command;
- on reaching WDOG_CYC-1, all CTRL and MODE registers clear to 0 and sWdogExpired sets;
- sWdogExpired stays set until the next accepted command clears it.
REQ-036 Without MCU_CTRL_WDOG_EN: no counter logic is present, sWdogExpired is constant 0, and WDOG_CYC is ignored.

Verification (NUM_CH=4, DATA_W=16)
REQ-037 Write CTRL ch2 (addr 0x8) = 0x00A5 -> RspValid 2 cycles after accept, RspErr=0; sChCtrl[47:32]=0x00A5; read addr 0x8 returns 0x00A5.
REQ-038 MODE ch0 = 0x0001, then CTRL ch0 = 0x0003 -> sChCtrl bit0 high for 1 cycle, bit1 stays high; read CTRL ch0 = 0x0002.
REQ-039 MODE ch1 = 0x0100, sChStatus bit16 rises 0->1 -> STICKY ch1 = 0x0001, sChIrq[1]=1 one cycle later; W1C 0x0001 -> sChIrq[1]=0.
REQ-040 Status rising edge coincident with W1C of the same bit -> bit remains 1.
REQ-041 Hold RspReady=0 for 5 cycles -> RspValid and RspRdata stable throughout, CmdReady=0; new command accepted only after the RspReady handshake.
REQ-042 With MCU_CTRL_WDOG_EN and WDOG_CYC=16, idle 16 cycles -> CTRL all 0 and sWdogExpired=1; next accepted command -> sWdogExpired=0.

Source files
------------

// File: rtl/mcu_ctrl_bridge.sv
// mcu_ctrl_bridge: MCU command/response bridge to per-channel CTRL/MODE/STATUS/STICKY registers.
// Optional watchdog enabled by defining MCU_CTRL_WDOG_EN.
module mcu_ctrl_bridge #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int WDOG_CYC = 100000000,
  localparam int ADDR_W = $clog2(NUM_CH) + 2
) (
  input  logic                     SysClk,
  input  logic                     sRst,
  input  logic                     sMcuCmdValid,
  output logic                     sMcuCmdReady,
  input  logic                     sMcuCmdWr,
  input  logic [ADDR_W-1:0]        sMcuCmdAddr,
  input  logic [DATA_W-1:0]        sMcuCmdWdata,
  output logic                     sMcuRspValid,
  input  logic                     sMcuRspReady,
  output logic [DATA_W-1:0]        sMcuRspRdata,
  output logic                     sMcuRspErr,
  output logic [NUM_CH*DATA_W-1:0] sChCtrl,
  input  logic [NUM_CH*DATA_W-1:0] sChStatus,
  output logic [NUM_CH-1:0]        sChIrq,
  output logic                     sWdogExpired
);
  localparam int H = DATA_W / 2;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q;
  logic wr_q, rsp_valid_q, rsp_err_q, bad, accept, we, wd_hit;
  logic [ADDR_W-1:0] addr_q, ch_idx;
  logic [1:0] reg_sel;
  logic [DATA_W-1:0] wdata_q, rsp_rdata_q, rd_d;
  logic [DATA_W-1:0] ctrl_q [NUM_CH];
  logic [DATA_W-1:0] ctrl_d [NUM_CH];
  logic [DATA_W-1:0] mode_q [NUM_CH];
  logic [DATA_W-1:0] mode_d [NUM_CH];
  logic [DATA_W-1:0] sticky_q [NUM_CH];
  logic [DATA_W-1:0] sticky_d [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] stat_q, rise;
  logic [NUM_CH-1:0] irq_q, irq_d;
  assign ch_idx = addr_q >> 2;
  assign reg_sel = addr_q[1:0];
  assign bad = ch_idx >= ADDR_W'(NUM_CH);
  assign sMcuCmdReady = (state_q == IDLE) && !sRst;
  assign accept = sMcuCmdValid && sMcuCmdReady;
  assign we = (state_q == EXEC) && wr_q && !bad;
  assign rise = sChStatus & ~stat_q;
  assign sMcuRspValid = rsp_valid_q;
  assign sMcuRspErr = rsp_err_q;
  assign sMcuRspRdata = rsp_rdata_q;
  assign sChIrq = irq_q;
  // Read mux, register next-state (write beats watchdog clear, sticky set beats W1C) and irq reduction
  always_comb begin
    rd_d = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch_idx == ADDR_W'(n)) rd_d = reg_sel == 2'd0 ? ctrl_q[n] & ~mode_q[n] : reg_sel == 2'd1 ? mode_q[n] : reg_sel == 2'd2 ? sChStatus[n*DATA_W +: DATA_W] : sticky_q[n];
      ctrl_d[n] = (we && ch_idx == ADDR_W'(n) && reg_sel == 2'd0) ? wdata_q : wd_hit ? '0 : ctrl_q[n] & ~mode_q[n];
      mode_d[n] = (we && ch_idx == ADDR_W'(n) && reg_sel == 2'd1) ? wdata_q : wd_hit ? '0 : mode_q[n];
      sticky_d[n] = (sticky_q[n] & ~((we && ch_idx == ADDR_W'(n) && reg_sel == 2'd3) ? wdata_q : '0)) | rise[n*DATA_W +: DATA_W];
      irq_d[n] = |(sticky_q[n][H-1:0] & mode_q[n][H +: H]);
      sChCtrl[n*DATA_W +: DATA_W] = ctrl_q[n];
    end
  end
  // Transaction FSM: latch command on accept, execute one cycle, hold response until consumed
  always_ff @(posedge SysClk) begin
    if (sRst) begin
      state_q <= IDLE;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (accept) begin
          state_q <= EXEC;
          wr_q <= sMcuCmdWr;
          addr_q <= sMcuCmdAddr;
          wdata_q <= sMcuCmdWdata;
        end
        EXEC: begin
          state_q <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q <= bad;
          rsp_rdata_q <= (wr_q || bad) ? '0 : rd_d;
        end
        RESP: if (sMcuRspReady) begin
          state_q <= IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Channel registers, status edge-detect delay and registered interrupts
  always_ff @(posedge SysClk) begin
    if (sRst) begin
      for (int n = 0; n < NUM_CH; n++) begin
        ctrl_q[n] <= '0;
        mode_q[n] <= '0;
        sticky_q[n] <= '0;
      end
      stat_q <= '0;
      irq_q <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        ctrl_q[n] <= ctrl_d[n];
        mode_q[n] <= mode_d[n];
        sticky_q[n] <= sticky_d[n];
      end
      stat_q <= sChStatus;
      irq_q <= irq_d;
    end
  end
`ifdef MCU_CTRL_WDOG_EN
  localparam int CW = $clog2(WDOG_CYC) + 1;
  logic [CW-1:0] wd_cnt_q;
  logic wd_exp_q;
  assign wd_hit = wd_cnt_q == CW'(WDOG_CYC - 1);
  assign sWdogExpired = wd_exp_q;
  // Watchdog counts idle cycles since the last accepted command and saturates once tripped
  always_ff @(posedge SysClk) begin
    if (sRst || accept) begin
      wd_cnt_q <= '0;
      wd_exp_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_hit ? wd_cnt_q : wd_cnt_q + 1'b1;
      wd_exp_q <= wd_exp_q || wd_hit;
    end
  end
`else
  assign wd_hit = WDOG_CYC < 0;
  assign sWdogExpired = 1'b0;
`endif
endmodule
